// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmitter and receiver so both sides agree
// on frame layout, FSM encoding and default baud divisor.
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 1000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_tx_if.sv
// Byte-write side of the UART transmitter: CPU write strobe and data in,
// queue status and the serial line out.
interface uart_tx_if;
  import uart_pkg::*;

  logic                 we;
  logic [DATA_BITS-1:0] din;
  logic                 full;
  logic                 busy;
  logic                 tx;

  modport master (output we, output din, input full, input busy, input tx);
  modport slave  (input we, input din, output full, output busy, output tx);

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous byte queue between the CPU write port and the serialiser.
// Pushes while full and pops while empty are ignored.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             empty_d_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;
  logic             full_q;
  logic             empty_q;
  logic             do_push_s;
  logic             do_pop_s;

  always_comb begin
    do_push_s = push_i && !full_q;
    do_pop_s  = pop_i && !empty_q;
    count_d   = count_q;
    if (do_push_s && !do_pop_s) begin
      count_d = count_q + CNT_ONE;
    end else if (!do_push_s && do_pop_s) begin
      count_d = count_q - CNT_ONE;
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push_s) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      count_q <= count_d;
      full_q  <= (count_d == CNT_DEPTH);
      empty_q <= (count_d == '0);
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  assign dout_o    = mem_q[rd_ptr_q];
  assign full_o    = full_q;
  assign empty_o   = empty_q;
  assign empty_d_o = (count_d == '0);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: queued bytes are sent LSB-first, CLKS_PER_BIT clocks
// per bit, with back-to-back frames sent without an idle gap.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic      clk,
  input  logic      rst,
  uart_tx_if.slave  bus
);

  localparam logic [15:0] CNT_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] CNT_ONE  = 16'd1;
  localparam logic [2:0]  IDX_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]  IDX_ONE  = 3'd1;

  uart_state_e          state_q, state_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 bit_end_s;
  logic                 pop_s;
  logic [DATA_BITS-1:0] fifo_dout_s;
  logic                 fifo_full_s;
  logic                 fifo_empty_s;
  logic                 fifo_empty_d_s;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (bus.we),
    .din_i     (bus.din),
    .pop_i     (pop_s),
    .dout_o    (fifo_dout_s),
    .full_o    (fifo_full_s),
    .empty_o   (fifo_empty_s),
    .empty_d_o (fifo_empty_d_s)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop_s     = 1'b0;
    bit_end_s = (cnt_q == CNT_LAST);
    case (state_q)
      IDLE: begin
        tx_d  = 1'b1;
        cnt_d = '0;
        idx_d = '0;
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          shift_d = fifo_dout_s;
          tx_d    = 1'b0;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (bit_end_s) begin
          cnt_d   = '0;
          idx_d   = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
            tx_d    = shift_q[1];
            idx_d   = idx_q + IDX_ONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STOP: begin
        if (bit_end_s) begin
          cnt_d = '0;
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty_s) begin
            pop_s   = 1'b1;
            shift_d = fifo_dout_s;
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
    busy_d = (state_d != IDLE) || !fifo_empty_d_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.tx   = tx_q;
  assign bus.busy = busy_q;
  assign bus.full = fifo_full_s;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a scoreboard of expected bytes is filled on
// accepted writes and drained by a line decoder that also checks bit timing.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int CPB_F = 4;
  localparam int CPB_S = 1000;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   fails  = 0;
  logic [7:0] exp_q [$];

  uart_tx_if f_if ();
  uart_tx_if s_if ();

  uart_tx #(.CLKS_PER_BIT(CPB_F), .FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (f_if)
  );

  uart_tx #(.CLKS_PER_BIT(CPB_S), .FIFO_DEPTH(4)) dut_slow (
    .clk (clk),
    .rst (rst),
    .bus (s_if)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic cur_tx(input int sel);
    return (sel == 0) ? f_if.tx : s_if.tx;
  endfunction

  // One write cycle; the byte joins the scoreboard only if it should be accepted.
  task automatic wr(input int sel, input logic [7:0] b, input bit accept);
    if (sel == 0) begin
      f_if.we = 1'b1; f_if.din = b;
    end else begin
      s_if.we = 1'b1; s_if.din = b;
    end
    if (accept) exp_q.push_back(b);
    @(posedge clk);
    #1;
    if (sel == 0) begin
      f_if.we = 1'b0; f_if.din = ~b;
    end else begin
      s_if.we = 1'b0; s_if.din = ~b;
    end
  endtask

  // Decode one frame; waited = idle cycles seen before the start bit.
  task automatic rx_frame(input int sel, input int cpb, output int waited);
    logic [9:0] bits;
    logic [7:0] exp_b;
    logic       s;
    int         bad;
    int         limit;
    bits   = '0;
    bad    = 0;
    waited = 0;
    limit  = 3 * cpb + 10;
    @(negedge clk);
    while (cur_tx(sel) !== 1'b0 && waited < limit) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= limit) begin
      check_val("rx_timeout", 32'(waited), 32'd0);
      return;
    end
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < cpb; c++) begin
        if (!(k == 0 && c == 0)) @(negedge clk);
        s = cur_tx(sel);
        if (c == 0) bits[k] = s;
        else if (s !== bits[k]) bad++;
      end
    end
    check_val("start_bit", {31'd0, bits[0]}, 32'd0);
    check_val("stop_bit", {31'd0, bits[9]}, 32'd1);
    check_val("bit_width", 32'(bad), 32'd0);
    if (exp_q.size() == 0) begin
      check_val("sb_underflow", {24'd0, bits[8:1]}, 32'hFFFF_FFFF);
    end else begin
      exp_b = exp_q.pop_front();
      check_val("rx_byte", {24'd0, bits[8:1]}, {24'd0, exp_b});
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int lows;
    rst = 1'b1;
    f_if.we = 1'b0; f_if.din = 8'h00;
    s_if.we = 1'b0; s_if.din = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_tx", {31'd0, f_if.tx}, 32'd1);
    check_val("rst_busy", {31'd0, f_if.busy}, 32'd0);
    check_val("rst_full", {31'd0, f_if.full}, 32'd0);
    check_val("rst_tx_slow", {31'd0, s_if.tx}, 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single byte with one cycle of write-to-start latency.
    wr(0, 8'h55, 1'b1);
    check_val("busy_on_push", {31'd0, f_if.busy}, 32'd1);
    rx_frame(0, CPB_F, w);
    check_val("latency", 32'(w), 32'd1);
    check_val("busy_at_stop", {31'd0, f_if.busy}, 32'd1);
    @(negedge clk);
    check_val("busy_drop", {31'd0, f_if.busy}, 32'd0);
    check_val("idle_tx", {31'd0, f_if.tx}, 32'd1);

    // Back-to-back frames with no idle gap.
    fork
      begin
        wr(0, 8'h01, 1'b1); wr(0, 8'h80, 1'b1);
        wr(0, 8'hFF, 1'b1); wr(0, 8'h00, 1'b1);
      end
      begin
        for (int i = 0; i < 4; i++) begin
          rx_frame(0, CPB_F, w);
          if (i > 0) check_val("b2b_gap", 32'(w), 32'd0);
        end
      end
    join
    @(negedge clk);
    check_val("b2b_busy_drop", {31'd0, f_if.busy}, 32'd0);

    // Fill the queue behind frame 0; the write after full is dropped.
    fork
      begin
        wr(0, 8'h10, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 1; i <= 4; i++) begin
          wr(0, 8'(8'h10 + i), 1'b1);
          if (i == 3) check_val("full_pre", {31'd0, f_if.full}, 32'd0);
        end
        check_val("full_set", {31'd0, f_if.full}, 32'd1);
        wr(0, 8'h15, 1'b0);
        check_val("full_hold", {31'd0, f_if.full}, 32'd1);
      end
      begin
        for (int i = 0; i < 5; i++) begin
          rx_frame(0, CPB_F, w);
          if (i > 0) check_val("full_gap", 32'(w), 32'd0);
        end
      end
    join
    @(negedge clk);
    check_val("drop_drained", 32'(exp_q.size()), 32'd0);

    // Write on the STOP-end pop edge while full is dropped; next cycle accepted.
    fork
      begin
        wr(0, 8'h20, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 1; i <= 4; i++) wr(0, 8'(8'h20 + i), 1'b1);
        repeat (34) @(posedge clk);
        #1;
        check_val("pp_full_before", {31'd0, f_if.full}, 32'd1);
        wr(0, 8'h99, 1'b0);
        check_val("pp_full_fall", {31'd0, f_if.full}, 32'd0);
        wr(0, 8'h25, 1'b1);
        check_val("pp_full_again", {31'd0, f_if.full}, 32'd1);
      end
      begin
        for (int i = 0; i < 6; i++) begin
          rx_frame(0, CPB_F, w);
          if (i > 0) check_val("pp_gap", 32'(w), 32'd0);
        end
      end
    join
    @(negedge clk);
    check_val("pp_busy_drop", {31'd0, f_if.busy}, 32'd0);

    // Asynchronous reset in the middle of a data bit flushes the queue.
    wr(0, 8'hA5, 1'b0);
    wr(0, 8'h5A, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    check_val("pre_rst_low", {31'd0, f_if.tx}, 32'd0);
    #1;
    rst = 1'b1;
    #1;
    check_val("arst_tx", {31'd0, f_if.tx}, 32'd1);
    check_val("arst_busy", {31'd0, f_if.busy}, 32'd0);
    check_val("arst_full", {31'd0, f_if.full}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (f_if.tx !== 1'b1 || f_if.busy !== 1'b0) lows++;
    end
    check_val("no_residual", 32'(lows), 32'd0);

    // Full-rate baud divisor on the second instance.
    fork
      wr(1, 8'h3C, 1'b1);
      rx_frame(1, CPB_S, w);
    join
    check_val("slow_latency", 32'(w), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
